// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;
   typedef enum logic [1:0] {FETCH, WAIT, HOLD} fetch_state_t;

   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/ifetch_ctrl.sv
// Fetch controller: one outstanding imem request; id_valid rises 1 cycle after rvalid and holds until id_ready.
// Define IFETCH_DELAY_SLOT_EN to keep the instruction after a branch (MIPS delay slot) instead of killing it.
module ifetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc4
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
   logic               discard_q, discard_d;
   logic               started_q, started_d;
   logic               id_valid_q, id_valid_d;
   logic [INSTR_W-1:0] id_instr_q, id_instr_d;
   logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
   logic [ADDR_W-1:0]  id_pc4_q, id_pc4_d;
`ifdef IFETCH_DELAY_SLOT_EN
   logic               pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
`endif

   logic               gnt_hs;
   logic [ADDR_W-1:0]  redir_pc;

   assign imem_req  = started_q && (state_q == FETCH);
   assign imem_addr = fetch_pc_q;
   assign gnt_hs    = imem_req && imem_gnt;
   assign redir_pc  = redirect_pc & ~ADDR_W'(3);

   assign id_valid  = id_valid_q;
   assign id_instr  = id_instr_q;
   assign id_pc     = id_pc_q;
   assign id_pc4    = id_pc4_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      discard_d  = discard_q;
      started_d  = 1'b1;
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_pc4_d   = id_pc4_q;
`ifdef IFETCH_DELAY_SLOT_EN
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
`endif

      case (state_q)
         FETCH: begin
            if (gnt_hs) begin
               state_d    = WAIT;
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
`ifdef IFETCH_DELAY_SLOT_EN
               if (pend_valid_q) begin
                  fetch_pc_d   = pend_pc_q;
                  pend_valid_d = 1'b0;
               end
`endif
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d = FETCH;
               if (discard_q) begin
                  discard_d = 1'b0;
               end else begin
                  state_d    = HOLD;
                  id_valid_d = 1'b1;
                  id_instr_d = imem_rdata;
                  id_pc_d    = req_pc_q;
                  id_pc4_d   = req_pc_q + ADDR_W'(PC_STEP);
               end
            end
         end
         HOLD: begin
            if (id_ready) begin
               state_d    = FETCH;
               id_valid_d = 1'b0;
            end
         end
         default: state_d = FETCH;
      endcase

`ifdef IFETCH_DELAY_SLOT_EN
      // The slot instruction finishes normally; only the next fetch address moves.
      if (redirect_valid) begin
         if (state_q == FETCH && !gnt_hs) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = redir_pc;
         end else begin
            fetch_pc_d = redir_pc;
         end
      end
`else
      // A response arriving in the redirect cycle is the outstanding one, so nothing is left to drop.
      if (redirect_valid) begin
         fetch_pc_d = redir_pc;
         id_valid_d = 1'b0;
         if ((state_q == WAIT && !imem_rvalid) || gnt_hs) begin
            discard_d = 1'b1;
            state_d   = WAIT;
         end else begin
            discard_d = 1'b0;
            state_d   = FETCH;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         discard_q  <= 1'b0;
         started_q  <= 1'b0;
         id_valid_q <= 1'b0;
         id_instr_q <= NOP_INSTR;
         id_pc_q    <= '0;
         id_pc4_q   <= '0;
`ifdef IFETCH_DELAY_SLOT_EN
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         discard_q  <= discard_d;
         started_q  <= started_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
         id_pc4_q   <= id_pc4_d;
`ifdef IFETCH_DELAY_SLOT_EN
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
`endif
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: expected fetch addresses and decode transfers are queued by the stimulus.
module tb_ifetch_ctrl;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } id_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_gnt, imem_rvalid = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid, id_ready;
   logic [31:0] id_instr, id_pc, id_pc4;

   logic        hi_req, hi_rvalid = 1'b0, hi_idv;
   logic [31:0] hi_addr, hi_rdata = '0, hi_instr, hi_pc, hi_pc4;

   logic        gnt_en;
   int          rsp_lat;
   int          checks = 0, errors = 0;
   int          xfer_cnt = 0, pushed = 0;
   logic [31:0] last_hs_addr;

   logic [31:0] exp_addr_q[$];
   id_t         exp_id_q[$];
   logic [31:0] hi_exp_addr_q[$];
   id_t         hi_exp_id_q[$];

   always #5 clk = ~clk;
   assign imem_gnt = gnt_en;

   ifetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4)
   );

   ifetch_ctrl #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
      .clk(clk), .rst(rst),
      .imem_req(hi_req), .imem_addr(hi_addr), .imem_gnt(1'b1),
      .imem_rvalid(hi_rvalid), .imem_rdata(hi_rdata),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .id_valid(hi_idv), .id_ready(1'b1),
      .id_instr(hi_instr), .id_pc(hi_pc), .id_pc4(hi_pc4)
   );

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a == 32'h0000_000C) ? 32'h2008_0005 : (32'h1300_0000 ^ a);
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_addr(input logic [31:0] a);
      exp_addr_q.push_back(a);
   endtask

   task automatic push_id(input logic [31:0] a);
      id_t e;
      e.instr = memfn(a);
      e.pc    = a;
      e.pc4   = a + 32'd4;
      exp_id_q.push_back(e);
      pushed++;
   endtask

   task automatic wait_all(input int budget, input string name);
      int n = 0;
      while (xfer_cnt < pushed && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check32({name, " transfers done"}, 32'(xfer_cnt), 32'(pushed));
   endtask

   task automatic wait_valid(input int budget, input string name);
      int n = 0;
      while (id_valid !== 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check32({name, " id_valid seen"}, 32'(id_valid), 32'd1);
   endtask

   // Memory model: grant is gnt_en, response rsp_lat cycles after the grant edge.
   logic        mem_hs;
   logic [31:0] mem_hs_addr, rsp_addr;
   int          mem_lat, rsp_cnt = 0;
   always begin
      @(negedge clk);
      mem_hs      = imem_req && imem_gnt;
      mem_hs_addr = imem_addr;
      mem_lat     = rsp_lat;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      if (mem_hs) begin
         rsp_cnt  = mem_lat;
         rsp_addr = mem_hs_addr;
      end
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(rsp_addr);
         end
      end
   end

   logic        hi_hs;
   logic [31:0] hi_hs_addr;
   always begin
      @(negedge clk);
      hi_hs      = hi_req;
      hi_hs_addr = hi_addr;
      @(posedge clk); #1;
      hi_rvalid = hi_hs;
      hi_rdata  = ~hi_hs_addr;
   end

   // Monitor: pops and compares whenever a request handshake or a decode transfer is presented.
   id_t mon_e;
   logic kill;
   always @(negedge clk) begin
`ifdef IFETCH_DELAY_SLOT_EN
      kill = 1'b0;
`else
      kill = redirect_valid;
`endif
      if (!rst) begin
         if (imem_req && imem_gnt) begin
            last_hs_addr = imem_addr;
            if (exp_addr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL imem_addr: unexpected request at %h, none expected", imem_addr);
            end else begin
               check32("imem_addr", imem_addr, exp_addr_q.pop_front());
            end
         end
         if (id_valid && id_ready && !kill) begin
            xfer_cnt++;
            if (exp_id_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL id transfer: unexpected pc %h, none expected", id_pc);
            end else begin
               mon_e = exp_id_q.pop_front();
               check32("id_instr", id_instr, mon_e.instr);
               check32("id_pc", id_pc, mon_e.pc);
               check32("id_pc4", id_pc4, mon_e.pc4);
            end
         end
         if (hi_req && hi_exp_addr_q.size() > 0)
            check32("hi imem_addr", hi_addr, hi_exp_addr_q.pop_front());
         if (hi_idv && hi_exp_id_q.size() > 0) begin
            mon_e = hi_exp_id_q.pop_front();
            check32("hi id_instr", hi_instr, mon_e.instr);
            check32("hi id_pc", hi_pc, mon_e.pc);
            check32("hi id_pc4", hi_pc4, mon_e.pc4);
         end
      end
   end

   initial begin
      id_t h;
      rst = 1'b1; id_ready = 1'b0; gnt_en = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; rsp_lat = 1;
      hi_exp_addr_q.push_back(32'hFFFF_FFFC);
      hi_exp_addr_q.push_back(32'h0000_0000);
      h.instr = 32'h0000_0003; h.pc = 32'hFFFF_FFFC; h.pc4 = 32'h0000_0000;
      hi_exp_id_q.push_back(h);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check32("reset id_valid", 32'(id_valid), 32'd0);
      check32("reset id_instr", id_instr, 32'd0);
      check32("reset id_pc", id_pc, 32'd0);
      check32("reset id_pc4", id_pc4, 32'd0);
      check32("reset imem_req", 32'(imem_req), 32'd0);

      // Back-to-back fetch with immediate grant and ready decode.
      push_addr(32'h0); push_addr(32'h4); push_addr(32'h8);
      push_id(32'h0); push_id(32'h4); push_id(32'h8);
      gnt_en = 1'b1; id_ready = 1'b1;
      wait_all(60, "sequential");
      gnt_en = 1'b0;

      // Decode stall in HOLD.
      push_addr(32'hC); push_id(32'hC);
      id_ready = 1'b0; gnt_en = 1'b1;
      wait_valid(20, "stall");
      for (int i = 0; i < 5; i++) begin
         check32("hold id_valid", 32'(id_valid), 32'd1);
         check32("hold id_instr", id_instr, 32'h2008_0005);
         check32("hold id_pc", id_pc, 32'hC);
         check32("hold imem_req", 32'(imem_req), 32'd0);
         @(posedge clk); #1;
      end
      id_ready = 1'b1; gnt_en = 1'b0;
      wait_all(20, "stall");

      // Redirect while a response is outstanding.
      rsp_lat = 3;
      push_addr(32'h10);
`ifdef IFETCH_DELAY_SLOT_EN
      push_id(32'h10);
`endif
      push_addr(32'h100); push_id(32'h100);
      gnt_en = 1'b1;
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0101;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      wait_all(60, "redirect in WAIT");
      gnt_en = 1'b0; rsp_lat = 1;

      // Redirect coincident with grant, then with id_ready in HOLD.
      id_ready = 1'b0;
      push_addr(32'h104);
`ifdef IFETCH_DELAY_SLOT_EN
      push_id(32'h104);
`else
      push_addr(32'h200);
`endif
      push_addr(32'h300); push_id(32'h300);
      gnt_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      wait_valid(20, "redirect on grant");
`ifdef IFETCH_DELAY_SLOT_EN
      check32("held pc after grant redirect", id_pc, 32'h104);
`else
      check32("held pc after grant redirect", id_pc, 32'h200);
`endif
      redirect_valid = 1'b1; redirect_pc = 32'h300; id_ready = 1'b1;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      check32("id_valid after HOLD redirect", 32'(id_valid), 32'd0);
      check32("imem_addr after HOLD redirect", imem_addr, 32'h300);
      wait_all(60, "redirect in HOLD");
      gnt_en = 1'b0;

      // Redirect in idle FETCH, then branch to 0x40 while 0x14 is in flight.
`ifdef IFETCH_DELAY_SLOT_EN
      push_addr(32'h304); push_id(32'h304);
      push_addr(32'h14); push_id(32'h14);
`else
      push_addr(32'h14);
`endif
      push_addr(32'h40); push_id(32'h40);
      redirect_valid = 1'b1; redirect_pc = 32'h14;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
`ifdef IFETCH_DELAY_SLOT_EN
      check32("imem_addr after FETCH redirect", imem_addr, 32'h304);
`else
      check32("imem_addr after FETCH redirect", imem_addr, 32'h14);
`endif
      rsp_lat = 2; gnt_en = 1'b1;
      begin
         int n = 0;
         while (last_hs_addr !== 32'h14 && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
      end
      check32("grant of 0x14 seen", last_hs_addr, 32'h14);
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      wait_all(60, "branch to 0x40");
      gnt_en = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check32("leftover expected requests", 32'(exp_addr_q.size()), 32'd0);
      check32("leftover expected transfers", 32'(exp_id_q.size()), 32'd0);
      check32("leftover hi requests", 32'(hi_exp_addr_q.size()), 32'd0);
      check32("leftover hi transfers", 32'(hi_exp_id_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Fetch-stage controller downstream of the PC register/incrementer; owns the architectural fetch PC.
- Issues instruction-memory requests and accepts responses.
- Delivers {instr, pc, pc+4} to the decode stage over a valid/ready handshake.
- Applies branch/jump redirects from decode/execute, discarding wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  word-aligned fetch address; bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle (imem_req && imem_gnt = handshake).
- imem_rvalid  in  1  response data valid; at least 1 cycle after grant; exactly one response per grant.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  ADDR_W  target address; bits [1:0] ignored and forced to 0.
- id_valid  out  1  instruction to decode valid.
- id_ready  in  1  decode accepts (id_valid && id_ready = transfer).
- id_instr  out  32  instruction word.
- id_pc  out  ADDR_W  address of id_instr.
- id_pc4  out  ADDR_W  id_pc + 4, modulo 2^ADDR_W.

Behaviour:
- Reset (rst high at posedge):
  - state=FETCH; fetch_pc=RESET_PC; discard=0.
  - imem_req=0 for the first cycle after reset; id_valid=0; id_instr=0; id_pc=0; id_pc4=0.
  - Reset mid-operation abandons any outstanding request; its response, if it arrives later, is dropped.
- At most one outstanding memory request. States FETCH, WAIT, HOLD.
- FETCH:
  - imem_req=1, imem_addr=fetch_pc.
  - On gnt: move to WAIT and set fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0).
- WAIT:
  - imem_req=0.
  - On rvalid with discard=1: drop data, clear discard, go to FETCH.
  - On rvalid with discard=0: register instr, pc, pc+4; id_valid=1 next cycle; go to HOLD.
- HOLD:
  - id_valid=1; outputs stable until transfer.
  - On id_ready: go to FETCH.
  - Sustained throughput is one instruction per 3 cycles minimum; bubbles are permitted.
- Latency: id_valid rises 1 cycle after rvalid.
- Redirect (feature disabled):
  - redirect_valid has priority over all other events in the same cycle.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
  - id_valid <= 0, so a held instruction is killed even if id_ready was high that cycle.
  - If an outstanding request exists or gnt occurs in this cycle: discard=1, state WAIT.
  - Otherwise: state FETCH.
- Redirect while discard=1 already: only fetch_pc updates; still exactly one response is dropped.
- id_ready with id_valid=0 is ignored. imem_rvalid outside WAIT is a protocol error and is ignored.

Optional Feature:
- Macro: IFETCH_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - Redirect does not kill the youngest instruction after the branch, i.e. the one in HOLD, in flight (WAIT), or being granted in FETCH.
  - That instruction completes and is delivered to decode normally.
  - redirect_pc is latched in pend_valid/pend_pc and loaded into fetch_pc when that instruction's request is granted. If it was already granted, pend_pc is loaded immediately.
  - In FETCH with no grant this cycle: the current request at fetch_pc completes as the slot, then fetch resumes at the target.
- Undefined: pend registers absent; behaviour as in Behaviour.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_state_t {FETCH, WAIT, HOLD}.
  - INSTR_W=32.
  - PC_STEP=4.
  - NOP_INSTR=32'h0000_0000.
- Single module, no sub-module needed; FSM and output register are tightly coupled.

Test Plan:
- Reset release, imem grants immediately, rvalid 1 cycle later, id_ready=1 -> addresses 0,4,8; id_pc=0/id_pc4=4, then 4/8, then 8/12; imem_req low the cycle after reset.
- id_ready held low 5 cycles in HOLD with instr 32'h2008_0005 -> id_valid/id_instr/id_pc stable; no new imem_req until transfer.
- Redirect to 32'h0000_0101 while in WAIT -> that response dropped; next imem_addr=32'h0000_0100; no id_valid for the dropped word.
- Redirect coincident with imem_gnt in FETCH and with id_ready in HOLD -> granted response discarded; held instruction not transferred; fetch resumes at target.
- RESET_PC=32'hFFFF_FFFC -> first id_pc4=0; second fetch address 0.
- IFETCH_DELAY_SLOT_EN: branch redirect to 32'h40 while fetching 32'h14 -> 32'h14 delivered, next fetch address 32'h40; with macro off, 32'h14 is dropped.
